// File: rtl/led_status_ctrl.sv
// led_status_ctrl: Avalon-MM programmable status LED driver.
// Each channel is OFF, ON, BLINK (prescaler tap) or PWM dim, gated by a global enable.
module led_status_ctrl #(
  parameter int unsigned N_LEDS     = 9,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned ALIVE_BIT  = 25,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk_100,
  input  logic              rstn,
  input  logic [4:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic [N_LEDS-1:0] leds
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam int unsigned       CHAN_BASE = 3;
  localparam logic [31:0]       ID_WORD   = {8'hA5, 8'd1, 8'(N_LEDS), 8'(CNT_W)};
  localparam logic [N_LEDS-1:0] INACTIVE  = {N_LEDS{ACTIVE_LOW}};

  logic              en_q, en_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  mode_e             mode_q [N_LEDS];
  mode_e             mode_d [N_LEDS];
  logic [7:0]        duty_q [N_LEDS];
  logic [7:0]        duty_d [N_LEDS];
  logic [4:0]        sel_q  [N_LEDS];
  logic [4:0]        sel_d  [N_LEDS];
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [N_LEDS-1:0] raw;
  logic [4:0]        tap;
  logic [CNT_W-1:0]  presc_sh;

  logic unused_wdata;
  assign unused_wdata = ^{avs_writedata[31:21], avs_writedata[7:2]};

  assign presc_d = presc_q + CNT_W'(1);

  // Register writes; RO and out-of-map addresses fall through untouched.
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    duty_d = duty_q;
    sel_d  = sel_q;
    if (avs_write) begin
      if (avs_address == 5'd0) begin
        en_d = avs_writedata[0];
      end
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        if (32'(avs_address) == CHAN_BASE + i) begin
          mode_d[i] = mode_e'(avs_writedata[1:0]);
          duty_d[i] = avs_writedata[15:8];
          sel_d[i]  = avs_writedata[20:16];
        end
      end
    end
  end

  // Reads sample the current (pre-write) register contents.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = avs_read;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        5'd0:    rdata_d[0] = en_q;
        5'd1:    rdata_d    = ID_WORD;
        5'd2:    rdata_d    = 32'(presc_q);
        default: begin
          for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (32'(avs_address) == CHAN_BASE + i) begin
              rdata_d = {11'd0, sel_q[i], duty_q[i], 6'd0, mode_q[i]};
            end
          end
        end
      endcase
    end
  end

  // Blink taps beyond the prescaler width clamp to its MSB.
  always_comb begin
    raw      = '0;
    tap      = '0;
    presc_sh = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      tap      = (32'(sel_q[i]) > CNT_W - 1) ? 5'(CNT_W - 1) : sel_q[i];
      presc_sh = presc_q >> tap;
      case (mode_q[i])
        MODE_OFF:   raw[i] = 1'b0;
        MODE_ON:    raw[i] = 1'b1;
        MODE_BLINK: raw[i] = presc_sh[0];
        MODE_PWM:   raw[i] = (presc_q[PWM_W-1:0] < duty_q[i][PWM_W-1:0]);
      endcase
    end
    leds_d = (en_q ? raw : '0) ^ INACTIVE;
  end

  always_ff @(posedge clk_100 or negedge rstn) begin
    if (!rstn) begin
      en_q     <= 1'b1;
      presc_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      leds_q   <= INACTIVE;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        mode_q[i] <= (i == N_LEDS - 1) ? MODE_BLINK : MODE_OFF;
        duty_q[i] <= '0;
        sel_q[i]  <= (i == N_LEDS - 1) ? 5'(ALIVE_BIT) : 5'd0;
      end
    end else begin
      en_q     <= en_d;
      presc_q  <= presc_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      leds_q   <= leds_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      sel_q    <= sel_d;
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign leds              = leds_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl (CNT_W=8, PWM_W=4, ALIVE_BIT=3), with an
// ACTIVE_LOW twin sharing the bus; both checked against a cycle-count reference model.
module tb_led_status_ctrl;
  localparam int N = 9;

  logic        clk_100 = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata, rd_al;
  logic        avs_readdatavalid, rv_al;
  logic [N-1:0] leds, leds_al;

  int total = 0;
  int bad = 0;

  led_status_ctrl #(.N_LEDS(N), .CNT_W(8), .PWM_W(4), .ALIVE_BIT(3), .ACTIVE_LOW(1'b0)) dut (
    .clk_100(clk_100), .rstn(rstn), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .leds(leds));

  led_status_ctrl #(.N_LEDS(N), .CNT_W(8), .PWM_W(4), .ALIVE_BIT(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk_100(clk_100), .rstn(rstn), .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rd_al),
    .avs_readdatavalid(rv_al), .leds(leds_al));

  always #5 clk_100 = ~clk_100;

  // Reference model: the prescaler is just cycles since reset modulo 256.
  int unsigned m_cnt = 0;
  int unsigned m_en = 1;
  int unsigned m_mode [N];
  int unsigned m_duty [N];
  int unsigned m_sel  [N];
  logic [N-1:0] exp_leds = '0;
  logic [31:0]  exp_rd = '0;
  logic         exp_rdv = 1'b0;

  function automatic logic led_on(int unsigned i);
    int unsigned s;
    case (m_mode[i])
      0: return 1'b0;
      1: return 1'b1;
      2: begin
        s = (m_sel[i] > 7) ? 7 : m_sel[i];
        return ((m_cnt >> s) & 1) == 1;
      end
      default: return (m_cnt % 16) < (m_duty[i] % 16);
    endcase
  endfunction

  function automatic logic [31:0] reg_val(int unsigned a);
    if (a == 0) return 32'(m_en);
    if (a == 1) return 32'hA5010900 + 32'd8;
    if (a == 2) return 32'(m_cnt);
    if (a >= 3 && a < 3 + N)
      return 32'(m_sel[a-3] * 65536 + m_duty[a-3] * 256 + m_mode[a-3]);
    return 32'd0;
  endfunction

  always @(posedge clk_100 or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0;
      m_en = 1;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_sel[i] = 0;
      end
      m_mode[N-1] = 2;
      m_sel[N-1] = 3;
      exp_leds = '0;
      exp_rd = '0;
      exp_rdv = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) exp_leds[i] = (m_en != 0) && led_on(i);
      exp_rdv = avs_read;
      if (avs_read) exp_rd = reg_val(avs_address);
      if (avs_write) begin
        if (avs_address == 0) m_en = avs_writedata[0];
        if (avs_address >= 3 && avs_address < 3 + N) begin
          m_mode[avs_address-3] = avs_writedata % 4;
          m_duty[avs_address-3] = (avs_writedata / 256) % 256;
          m_sel[avs_address-3]  = (avs_writedata / 65536) % 32;
        end
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  end

  task automatic tick();
    @(posedge clk_100);
    @(negedge clk_100);
  endtask

  task automatic bus(input logic wr, input logic rd, input logic [4:0] a, input logic [31:0] d);
    avs_write = wr; avs_read = rd; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0; avs_read = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    total++;
    if (leds !== '0 || leds_al !== '1) begin
      bad++; $display("FAIL reset_leds: got %b/%b want all 0 / all 1", leds, leds_al);
    end
    total++;
    if (avs_readdata !== '0 || avs_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL reset_bus: got rd=%h rv=%b want 0/0", avs_readdata, avs_readdatavalid);
    end
    rstn = 1'b1;
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (leds[N-1]) highs++;
      total++;
      if (leds !== exp_leds || leds_al !== ~exp_leds) begin
        bad++; $display("FAIL alive_leds: got %b/%b want %b", leds, leds_al, exp_leds);
      end
    end
    total++;
    if (highs != 16) begin bad++; $display("FAIL alive_duty: got %0d high want 16", highs); end
    bus(1'b0, 1'b1, 5'd1, 32'd0);
    total++;
    if (avs_readdata !== 32'hA5010908 || avs_readdatavalid !== 1'b1) begin
      bad++; $display("FAIL id_read: got %h rv=%b want a5010908", avs_readdata, avs_readdatavalid);
    end
  endtask

  task automatic test_on_off();
    bus(1'b1, 1'b0, 5'd3, 32'd1);
    total++;
    if (leds[0] !== 1'b0) begin bad++; $display("FAIL on_early: got %b want 0", leds[0]); end
    tick();
    total++;
    if (leds[0] !== 1'b1 || leds_al[0] !== 1'b0) begin
      bad++; $display("FAIL on_t2: got %b/%b want 1/0", leds[0], leds_al[0]);
    end
    bus(1'b1, 1'b0, 5'd3, 32'd0);
    total++;
    if (leds[0] !== 1'b1) begin bad++; $display("FAIL off_early: got %b want 1", leds[0]); end
    tick();
    total++;
    if (leds[0] !== 1'b0) begin bad++; $display("FAIL off_t2: got %b want 0", leds[0]); end
  endtask

  task automatic test_pwm();
    int duties [3] = '{5, 0, 15};
    int highs;
    for (int d = 0; d < 3; d++) begin
      bus(1'b1, 1'b0, 5'd4, 32'(duties[d] * 256 + 3));
      tick();
      highs = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (leds[1]) highs++;
        total++;
        if (leds !== exp_leds || leds_al !== ~exp_leds) begin
          bad++; $display("FAIL pwm_leds: got %b/%b want %b", leds, leds_al, exp_leds);
        end
      end
      total++;
      if (highs != duties[d]) begin
        bad++; $display("FAIL pwm_count: duty %0d got %0d high want %0d", duties[d], highs, duties[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus(1'b1, 1'b1, 5'd5, 32'd2);
    total++;
    if (avs_readdata !== 32'd0 || avs_readdatavalid !== 1'b1) begin
      bad++; $display("FAIL rw_same: got %h rv=%b want 0 rv=1", avs_readdata, avs_readdatavalid);
    end
    tick();
    total++;
    if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL rv_pulse: got %b want 0", avs_readdatavalid); end
    bus(1'b0, 1'b1, 5'd5, 32'd0);
    total++;
    if (avs_readdata !== 32'd2) begin bad++; $display("FAIL rw_new: got %h want 2", avs_readdata); end
    bus(1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF);
    bus(1'b0, 1'b1, 5'd31, 32'd0);
    total++;
    if (avs_readdata !== 32'd0) begin bad++; $display("FAIL addr31: got %h want 0", avs_readdata); end
  endtask

  task automatic test_disable();
    logic [31:0] p1;
    bus(1'b1, 1'b0, 5'd3, 32'd1);
    bus(1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    total++;
    if (leds !== '0 || leds_al !== '1) begin
      bad++; $display("FAIL disabled: got %b/%b want all 0 / all 1", leds, leds_al);
    end
    bus(1'b0, 1'b1, 5'd2, 32'd0);
    p1 = avs_readdata;
    total++;
    if (avs_readdata !== exp_rd) begin bad++; $display("FAIL presc1: got %h want %h", avs_readdata, exp_rd); end
    repeat (4) tick();
    bus(1'b0, 1'b1, 5'd2, 32'd0);
    total++;
    if (avs_readdata !== 32'((p1 + 5) % 256)) begin
      bad++; $display("FAIL presc_run: got %h want %h", avs_readdata, 32'((p1 + 5) % 256));
    end
    bus(1'b1, 1'b0, 5'd0, 32'd1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      total++;
      if (leds !== exp_leds || leds_al !== ~exp_leds) begin
        bad++; $display("FAIL rand_leds: cyc %0d got %b/%b want %b", k, leds, leds_al, exp_leds);
      end
      total++;
      if (avs_readdatavalid !== exp_rdv || (exp_rdv && avs_readdata !== exp_rd)) begin
        bad++; $display("FAIL rand_read: cyc %0d got %h rv=%b want %h rv=%b",
                        k, avs_readdata, avs_readdatavalid, exp_rd, exp_rdv);
      end
      avs_write = ($urandom_range(0, 2) == 0);
      avs_read = $urandom_range(0, 1);
      avs_address = avs_write ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
      avs_writedata = $urandom();
      if (avs_write && avs_address == 5'd0) avs_writedata[0] = ($urandom_range(0, 3) != 0);
      tick();
    end
    avs_write = 1'b0; avs_read = 1'b0;
    bus(1'b1, 1'b0, 5'd0, 32'd1);
  endtask

  task automatic test_reset_mid();
    bus(1'b1, 1'b0, 5'd4, 32'h0000_0703);
    bus(1'b1, 1'b0, 5'd11, 32'h0000_0001);
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    total++;
    if (leds !== '0 || leds_al !== '1) begin
      bad++; $display("FAIL rst_mid_leds: got %b/%b want all 0 / all 1", leds, leds_al);
    end
    tick();
    rstn = 1'b1;
    bus(1'b0, 1'b1, 5'd4, 32'd0);
    total++;
    if (avs_readdata !== 32'd0) begin bad++; $display("FAIL rst_chan1: got %h want 0", avs_readdata); end
    bus(1'b0, 1'b1, 5'd11, 32'd0);
    total++;
    if (avs_readdata !== 32'h0003_0002) begin bad++; $display("FAIL rst_chan8: got %h want 00030002", avs_readdata); end
    bus(1'b0, 1'b1, 5'd0, 32'd0);
    total++;
    if (avs_readdata !== 32'd1) begin bad++; $display("FAIL rst_ctrl: got %h want 1", avs_readdata); end
    total++;
    if (leds !== exp_leds) begin bad++; $display("FAIL rst_after: got %b want %b", leds, exp_leds); end
  endtask

  initial begin
    repeat (3) @(negedge clk_100);
    test_reset();
    test_on_off();
    test_pwm();
    test_back_to_back();
    test_disable();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
